// File: rtl/cache_mem_responder_pkg.sv
// Shared cache memory bus constants used by the responder and its line array.
package cache_mem_responder_pkg;

    localparam int unsigned CMR_ADDR_W     = 32;
    localparam int unsigned CMR_DATA_W     = 128;
    localparam int unsigned CMR_BE_W       = CMR_DATA_W / 8;
    localparam int unsigned CMR_DEPTH_LOG2 = 10;
    localparam int unsigned CMR_LATENCY    = 4;
    localparam int unsigned CMR_CNT_W      = 4;

    typedef logic [CMR_CNT_W-1:0] cmr_cnt_t;

endpackage

// File: rtl/mem_line_array.sv
// Byte-enabled single-port line RAM: registered write, combinational read.
module mem_line_array
    import cache_mem_responder_pkg::*;
#(
    parameter int unsigned DATA_W     = CMR_DATA_W,
    parameter int unsigned DEPTH_LOG2 = CMR_DEPTH_LOG2
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [DEPTH_LOG2-1:0] i_addr,
    input  logic [DATA_W/8-1:0]   i_be,
    input  logic [DATA_W-1:0]     i_wdata,
    output logic [DATA_W-1:0]     o_rdata
);

    localparam int unsigned Depth = 32'd1 << DEPTH_LOG2;

    // Contents are deliberately not reset.
    logic [DATA_W-1:0] mem_q [Depth];

    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int b = 0; b < int'(DATA_W / 8); b++) begin
                if (i_be[b]) begin
                    mem_q[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
                end
            end
        end
    end

    assign o_rdata = mem_q[i_addr];

endmodule

// File: rtl/cache_mem_responder.sv
// Fixed-latency cache line responder. Define CACHE_MEM_RESP_WRITE_EN to let writes
// update the array; otherwise writes are timed normally but dropped (instruction ROM).
module cache_mem_responder
    import cache_mem_responder_pkg::*;
#(
    parameter int unsigned ADDR_W     = CMR_ADDR_W,
    parameter int unsigned DATA_W     = CMR_DATA_W,
    parameter int unsigned DEPTH_LOG2 = CMR_DEPTH_LOG2,
    parameter int unsigned LATENCY    = CMR_LATENCY
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [ADDR_W-1:0]   i_m_addr,
    input  logic [DATA_W/8-1:0] i_m_byte_en,
    input  logic [DATA_W-1:0]   i_m_writedata,
    input  logic                i_m_read,
    input  logic                i_m_write,
    output logic [DATA_W-1:0]   o_m_readdata,
    output logic                o_m_readdata_valid,
    output logic                o_m_waitrequest
);

    localparam int unsigned BeW = DATA_W / 8;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]            state_q, state_d;
    cmr_cnt_t              cnt_q, cnt_d;
    logic [DEPTH_LOG2-1:0] idx_q, idx_d;
    logic [BeW-1:0]        be_q, be_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic [DATA_W-1:0]     rdata_q, rdata_d;
    logic                  is_wr_q, is_wr_d;
    logic                  ready_q, ready_d;
    logic [DATA_W-1:0]     mem_rdata;
    logic                  accept;
    logic                  mem_we;
    logic                  unused_addr;

    assign unused_addr = ^i_m_addr[ADDR_W-1:DEPTH_LOG2];

    // ready_q keeps waitrequest high through reset and the first cycle after it.
    assign o_m_waitrequest    = !ready_q || (state_q != IDLE);
    assign accept             = (i_m_read | i_m_write) && !o_m_waitrequest;
    assign o_m_readdata_valid = (state_q == RESP) && !is_wr_q;
    assign o_m_readdata       = o_m_readdata_valid ? mem_rdata : rdata_q;

`ifdef CACHE_MEM_RESP_WRITE_EN
    assign mem_we = (state_q == RESP) && is_wr_q;
`else
    assign mem_we = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        is_wr_d = is_wr_q;
        rdata_d = rdata_q;
        ready_d = 1'b1;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = BUSY;
                    cnt_d   = CMR_CNT_W'(LATENCY - 1);
                    idx_d   = i_m_addr[DEPTH_LOG2-1:0];
                    be_d    = i_m_byte_en;
                    wdata_d = i_m_writedata;
                    is_wr_d = i_m_write;
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
                if (!is_wr_q) begin
                    rdata_d = mem_rdata;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            is_wr_q <= 1'b0;
            rdata_q <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            is_wr_q <= is_wr_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
        end
    end

    mem_line_array #(
        .DATA_W     (DATA_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_mem (
        .clk     (clk),
        .i_we    (mem_we),
        .i_addr  (idx_q),
        .i_be    (be_q),
        .i_wdata (wdata_q),
        .o_rdata (mem_rdata)
    );

endmodule

// File: doc/cache_mem_responder.md
CACHE_MEM_RESPONDER -- requirements
Module: cache_mem_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning the width of the line address from the cache master.
REQ-002 SHALL have parameter DATA_W, default 128, meaning the cache-line width in bits; it SHALL be a multiple of 8.
REQ-003 SHALL have parameter DEPTH_LOG2, default 10, meaning log2 of the number of lines stored.
REQ-004 SHALL have parameter LATENCY, default 4, legal range 1..15, meaning the cycles from command accept to completion.
REQ-005 SHALL have port clk  input  1  system clock; all state SHALL change on the rising edge.
REQ-006 SHALL have port rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-007 SHALL have port i_m_addr  input  ADDR_W  line address from the cache.
REQ-008 SHALL have port i_m_byte_en  input  DATA_W/8  write byte mask.
REQ-009 SHALL have port i_m_writedata  input  DATA_W  write data.
REQ-010 SHALL have port i_m_read  input  1  read command.
REQ-011 SHALL have port i_m_write  input  1  write command.
REQ-012 SHALL have port o_m_readdata  output  DATA_W  read data.
REQ-013 SHALL have port o_m_readdata_valid  output  1  one-cycle pulse qualifying o_m_readdata.
REQ-014 SHALL have port o_m_waitrequest  output  1  high while the responder cannot accept a command.

Function
REQ-015 A command SHALL be accepted on a clock edge where (i_m_read|i_m_write)=1 and o_m_waitrequest=0; address, mask, data and type SHALL be captured on that edge.
REQ-016 The FSM SHALL have states IDLE, BUSY and RESP; o_m_waitrequest SHALL be 0 only in IDLE.
REQ-017 IDLE->BUSY on accept, loading counter with LATENCY-1; BUSY decrements each cycle; on counter==0 it goes to RESP.
REQ-018 RESP SHALL last exactly one cycle, then return to IDLE; for a read, o_m_readdata_valid=1 and o_m_readdata=line[index] during RESP.
REQ-019 For a write, during RESP the responder SHALL update line[index] only in the bytes whose i_m_byte_en bit was set at accept; o_m_readdata_valid SHALL stay 0.
REQ-020 Accept-to-valid latency SHALL be LATENCY+1 cycles (accept edge to valid-high edge); back-to-back throughput SHALL be one command per LATENCY+2 cycles.
REQ-021 index SHALL be i_m_addr[DEPTH_LOG2-1:0]; upper address bits SHALL be ignored, so addresses wrap modulo 2^DEPTH_LOG2.
REQ-022 If i_m_read and i_m_write are both 1 at accept, the command SHALL be treated as a write.
REQ-023 Commands presented while o_m_waitrequest=1 SHALL be ignored and SHALL NOT alter captured fields; the master is required to hold them.
REQ-024 A read issued immediately after a write to the same index SHALL return the newly written data.
REQ-025 o_m_readdata SHALL hold its last value outside RESP.

Reset
REQ-026 On rst_n=0, regardless of the current state, the FSM SHALL go to IDLE, the counter SHALL clear, o_m_readdata_valid=0 and o_m_readdata=0; o_m_waitrequest SHALL be 1 while rst_n=0.
REQ-027 An in-flight write SHALL be discarded by reset; the memory array contents SHALL NOT be reset.

Configuration
REQ-028 With macro CACHE_MEM_RESP_WRITE_EN defined, writes SHALL behave as specified in REQ-019.
REQ-029 Without CACHE_MEM_RESP_WRITE_EN, writes SHALL be accepted and timed identically, but the array SHALL NOT change, making the block a read-only instruction ROM.

Structure
REQ-030 The bus widths (line address, byte enable, line data) SHALL come from the shared defines header alongside the existing cache memory bus constants; the FSM state encodings SHALL be local constants.
REQ-031 Storage SHALL be one sub-module, mem_line_array: a byte-enabled single-port RAM with registered write and combinational read.

Verification
REQ-032 Reset, then read addr 0x5 with array preloaded to 0xA5A5...: waitrequest=1 for 5 cycles (LATENCY=4), valid pulses once with 0xA5A5....
REQ-033 Write 0xFFFF...FFFF with byte_en=0x000F to addr 3 (prior value 0), then read addr 3: the read returns 0x0000...0000_FFFF_FFFF.
REQ-034 Read addr 0x403 with DEPTH_LOG2=10: the read returns line 3's contents (wrap-around).
REQ-035 Assert read+write together at addr 7 with data 0x1234: it is treated as a write (no valid pulse), and a later read of addr 7 returns 0x1234.
REQ-036 Drop rst_n low during BUSY of a write to addr 9: no valid pulse occurs, line 9 is unchanged, and waitrequest=0 one cycle after rst_n rises.
REQ-037 Build without CACHE_MEM_RESP_WRITE_EN and write addr 2: timing is identical to the write build, and a readback returns the original contents.
